// File: rtl/halton_point_scheduler.sv
// -----------------------------------------------------------------------------
// halton_point_scheduler
//
// Shares one two-dimensional Halton generator (base 2 / base 3) between
// NUM_REQ requesters. A round-robin arbiter picks one requester at a time.
// The scheduler then issues either a single-cycle reseed or a single-cycle pop
// to the generator. For a pop, it captures the generator's point and returns it
// to the requester over a valid/ready handshake. A watchdog converts a
// generator that never answers into an error response.
//
// Ports
//   i_clk                 clock, rising edge
//   i_rst                 synchronous active-high reset
//   i_req_valid[N]        requester i wants one point (held until o_grant[i])
//   i_req_reseed[N]       requester i wants a reseed (held until o_grant[i])
//   i_req_seed[32N]       seed of requester i in [32i+31:32i]
//   o_grant[N]            one-hot acceptance pulse (first RESEED/POP cycle)
//   o_resp_valid[N]       one-hot, response pending for requester i
//   i_resp_ready[N]       requester i accepts the response
//   o_resp_x / o_resp_y   base-2 / base-3 coordinate of the response
//   o_resp_err            response produced by the watchdog (coords are 0)
//   o_gen_pop_enable      pop pulse to the generator
//   o_gen_reseed_enable   reseed pulse to the generator
//   o_gen_seed            seed to the generator, non-zero only while reseeding
//   i_gen_out_0/1         generator base-2 / base-3 outputs
//   i_gen_valid           generator output valid (only looked at in WAIT)
//   o_busy                scheduler is not IDLE
//   o_timeout_count       saturating count of watchdog expiries
//
// State   | Meaning
// --------+---------------------------------------------------------------
// IDLE    | arbitrate; winner, seed and kind latched on leaving
// RESEED  | one cycle of gen reseed pulse + grant, then back to IDLE
// POP     | one cycle of gen pop pulse + grant, wait counter cleared
// WAIT    | wait for gen_valid or watchdog expiry
// RESP    | response held for the winner until it handshakes
//
// Every output is either a register or decoded from registered state, so
// there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module halton_point_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [NUM_REQ-1:0]     i_req_reseed,
  input  logic [32*NUM_REQ-1:0]  i_req_seed,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [NUM_REQ-1:0]     o_resp_valid,
  input  logic [NUM_REQ-1:0]     i_resp_ready,
  output logic [31:0]            o_resp_x,
  output logic [31:0]            o_resp_y,
  output logic                   o_resp_err,
  output logic                   o_gen_pop_enable,
  output logic                   o_gen_reseed_enable,
  output logic [31:0]            o_gen_seed,
  input  logic [31:0]            i_gen_out_0,
  input  logic [31:0]            i_gen_out_1,
  input  logic                   i_gen_valid,
  output logic                   o_busy,
  output logic [7:0]             o_timeout_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESEED,
    S_POP,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_winner;
  logic [31:0]        r_seed;
  logic [7:0]         r_wait_cnt;
  logic [31:0]        r_resp_x;
  logic [31:0]        r_resp_y;
  logic               r_resp_err;
  logic [7:0]         r_timeout_count;

  logic [NUM_REQ-1:0] w_cand;
  logic [IDX_W-1:0]   w_winner;
  logic               w_found;
  logic [31:0]        w_seed_sel;
  logic               w_accept;
  logic               w_capture;
  logic               w_timeout;
  logic [NUM_REQ-1:0] w_winner_oh;

  // Round-robin search starting just after the last winner.
  always_comb begin
    w_cand   = i_req_valid | i_req_reseed;
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!w_found && w_cand[(int'(r_ptr) + off) % NUM_REQ]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'((int'(r_ptr) + off) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_seed_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IDX_W'(i)) begin
        w_seed_sel = i_req_seed[32*i +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_accept = 1'b1;
          // A reseed wins over a pop from the same requester; the pop
          // stays pending and is served in a later round.
          w_state_nxt = i_req_reseed[w_winner] ? S_RESEED : S_POP;
        end
      end
      S_RESEED: w_state_nxt = S_IDLE;
      S_POP:    w_state_nxt = S_WAIT;
      S_WAIT: begin
        // gen_valid in the last allowed cycle still counts as an answer.
        if (i_gen_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (i_resp_ready[r_winner]) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr           <= IDX_W'(NUM_REQ - 1);
      r_winner        <= '0;
      r_seed          <= '0;
      r_wait_cnt      <= '0;
      r_resp_x        <= '0;
      r_resp_y        <= '0;
      r_resp_err      <= 1'b0;
      r_timeout_count <= '0;
    end else begin
      if (w_accept) begin
        r_ptr    <= w_winner;
        r_winner <= w_winner;
        r_seed   <= w_seed_sel;
      end

      // Counts completed WAIT cycles without an answer.
      if (r_state == S_POP) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_WAIT && !i_gen_valid) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end

      if (w_capture) begin
        r_resp_x   <= i_gen_out_0;
        r_resp_y   <= i_gen_out_1;
        r_resp_err <= 1'b0;
      end else if (w_timeout) begin
        r_resp_x   <= '0;
        r_resp_y   <= '0;
        r_resp_err <= 1'b1;
        if (r_timeout_count != 8'hFF) begin
          r_timeout_count <= r_timeout_count + 8'd1;
        end
      end
    end
  end

  // State-decoded outputs.
  assign w_winner_oh = NUM_REQ'(1) << r_winner;

  assign o_grant             = (r_state == S_RESEED || r_state == S_POP) ? w_winner_oh : '0;
  assign o_resp_valid        = (r_state == S_RESP) ? w_winner_oh : '0;
  assign o_resp_x            = r_resp_x;
  assign o_resp_y            = r_resp_y;
  assign o_resp_err          = r_resp_err;
  assign o_gen_pop_enable    = (r_state == S_POP);
  assign o_gen_reseed_enable = (r_state == S_RESEED);
  assign o_gen_seed          = (r_state == S_RESEED) ? r_seed : '0;
  assign o_busy              = (r_state != S_IDLE);
  assign o_timeout_count     = r_timeout_count;

endmodule

// File: doc/halton_point_scheduler.md
Name: halton_point_scheduler

Overview:
- Shares one two-dimensional Halton generator (bases 2/3, fixed-point scales 11/7) between NUM_REQ requesters.
- Round-robin arbitration between requesters.
- Issues single-cycle pop and reseed commands to the generator and captures its outputs.
- Returns each point to its requester over a valid/ready handshake.
- Includes a watchdog for a generator that never answers.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- TIMEOUT, 15: maximum WAIT cycles allowed for gen_valid before an error response (1..255).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, synchronous, active-high.
- req_valid, in, NUM_REQ: requester i wants one point; held until grant[i].
- req_reseed, in, NUM_REQ: requester i wants a reseed; held until grant[i].
- req_seed, in, 32*NUM_REQ: seed for requester i, in slice [32i+31:32i].
- grant, out, NUM_REQ: one-hot, one-cycle acceptance pulse.
- resp_valid, out, NUM_REQ: one-hot, response pending for requester i.
- resp_ready, in, NUM_REQ: requester i accepts the response.
- resp_x, out, 32: base-2 coordinate of the response.
- resp_y, out, 32: base-3 coordinate of the response.
- resp_err, out, 1: response produced by timeout; resp_x and resp_y are 0.
- gen_pop_enable, out, 1: pop pulse to the generator.
- gen_reseed_enable, out, 1: reseed pulse to the generator.
- gen_seed, out, 32: seed to the generator; valid while gen_reseed_enable is high.
- gen_out_0, in, 32: generator base-2 output.
- gen_out_1, in, 32: generator base-3 output.
- gen_valid, in, 1: generator output valid.
- busy, out, 1: state is not IDLE.
- timeout_count, out, 8: number of timeouts, saturates at 255.

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE, RR pointer=NUM_REQ-1.
  - All outputs 0, timeout_count=0.
  - Reset mid-operation aborts the transaction and discards any pending response.
- States: IDLE, RESEED, POP, WAIT, RESP. All outputs are registered or state-decoded; no combinational path from inputs to outputs.
- IDLE:
  - Candidate i = req_valid[i] | req_reseed[i].
  - Winner is the first candidate searching from pointer+1 modulo NUM_REQ. The pointer then moves to the winner, and the seed and kind are latched.
  - If req_reseed[winner] is set, next state is RESEED (reseed takes precedence); otherwise POP.
  - With no candidates, stay in IDLE.
- grant[winner]=1 for exactly the first cycle of RESEED or POP. A requester may drop its request from the next cycle.
  - If both bits were set, only the reseed is consumed. req_valid must stay high and is served in a later round.
- RESEED: one cycle with gen_reseed_enable=1 and gen_seed=latched seed, then IDLE. No response is produced.
- POP: one cycle with gen_pop_enable=1, then WAIT. The wait counter is cleared.
- WAIT:
  - If gen_valid=1, capture gen_out_0 into resp_x and gen_out_1 into resp_y, clear resp_err, go to RESP.
  - Otherwise increment the counter. At the edge ending the TIMEOUT-th WAIT cycle, set resp_x=0, resp_y=0, resp_err=1, increment timeout_count (saturating), go to RESP.
  - gen_valid in that final cycle wins over timeout.
- gen_valid is ignored outside WAIT.
- RESP:
  - resp_valid[winner]=1; resp_x, resp_y and resp_err are held stable.
  - Leave on resp_valid[winner] & resp_ready[winner] at an edge, then IDLE; resp_valid drops the next cycle.
  - resp_ready of other requesters is ignored.
- Latency (request in IDLE at cycle 0, generator latency 1):
  - grant and gen_pop_enable in cycle 1.
  - WAIT in cycle 2 sees gen_valid.
  - resp_valid in cycle 3.
- Throughput: at most one point per 4 cycles (IDLE, POP, WAIT, RESP); one reseed per 2 cycles.
- busy = (state != IDLE).

Test Plan:
- Single point, latency 1: reset, then req_valid=0001 → grant=0001 in cycle 1, resp_valid=0001 in cycle 3, resp_x=1024, resp_y=729, resp_err=0.
  - The bench uses a behavioural generator model with scales 11/7 and programmable latency L.
- Round robin: all four req_valid held, resp_ready tied to 1 → grants in order 0,1,2,3,0. Points k=1..4 are [1024,729], [512,1458], [1536,243], [256,972].
- Reseed precedence: requester 2 raises req_reseed=1, req_seed=5 and req_valid together → cycle 1 gen_reseed_enable=1, gen_seed=5, no response. Next grant to 2 is a POP, responding [768,486] (k=6).
- Backpressure: hold resp_ready=0 for 10 cycles → resp_valid, resp_x and resp_y stay stable. No new grant and busy=1 until the handshake.
- Timeout: model never asserts gen_valid → after 15 WAIT cycles resp_err=1, resp_x=0, resp_y=0, timeout_count=1.
  - Repeat with gen_valid in the 15th WAIT cycle → normal response, resp_err=0.
- Reset mid-WAIT: assert rst → next cycle all outputs 0 and busy=0. The next request goes to requester 0 first.
